// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: latches three 16.16 vertices, derives the screen-clamped
// integer pixel box and streams every pixel in raster order (x fastest) with last/done flags.
module tri_bbox_scanner #(
    parameter int COORD_WIDTH = 32,
    parameter int FRAC_BITS   = 16,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 180,
    parameter int PIX_W       = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H)
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic signed [2:0][COORD_WIDTH-1:0] a,
    input  logic signed [2:0][COORD_WIDTH-1:0] b,
    input  logic signed [2:0][COORD_WIDTH-1:0] c,
    input  logic                               tri_valid,
    output logic                               tri_ready,
    output logic signed [2:0][COORD_WIDTH-1:0] p,
    output logic [PIX_W-1:0]                   px,
    output logic [PIX_W-1:0]                   py,
    output logic                               p_valid,
    input  logic                               p_ready,
    output logic                               p_last,
    output logic                               done,
    output logic                               busy
);

    localparam int IW = COORD_WIDTH - FRAC_BITS;
    localparam logic signed [IW-1:0] XLIM = IW'(SCREEN_W - 1);
    localparam logic signed [IW-1:0] YLIM = IW'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BBOX,
        S_CLAMP,
        S_SCAN,
        S_FINISH
    } state_t;

    state_t state_q, state_d;
    logic   bbox_step_q;

    logic [COORD_WIDTH-1:0] vin_x [3];
    logic [COORD_WIDTH-1:0] vin_y [3];
    logic signed [IW-1:0]   ix [3];
    logic signed [IW-1:0]   iy [3];

    logic signed [IW-1:0] bxmin_q, bxmax_q, bymin_q, bymax_q;
    logic [PIX_W-1:0]     xmin_q, xmax_q, ymax_q, px_q, py_q;

    logic accept, floor_en, minmax_en, empty, at_last;
    logic signed [IW-1:0] cx_lo, cx_hi, cy_lo, cy_hi;

    assign vin_x[0] = a[0];
    assign vin_x[1] = b[0];
    assign vin_x[2] = c[0];
    assign vin_y[0] = a[1];
    assign vin_y[1] = b[1];
    assign vin_y[2] = c[1];

    logic unused_z;
    assign unused_z = ^{a[2], b[2], c[2]};

    assign accept    = (state_q == S_IDLE) && tri_valid;
    assign floor_en  = (state_q == S_BBOX) && !bbox_step_q;
    assign minmax_en = (state_q == S_BBOX) && bbox_step_q;

    // Box derivation takes two cycles (floor, then min/max) so the first pixel
    // appears three edges after acceptance.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_vtx
            logic [COORD_WIDTH-1:0] vx_q, vy_q;
            logic signed [IW-1:0]   ix_q, iy_q;
            logic                   unused_frac;

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    vx_q <= '0;
                    vy_q <= '0;
                    ix_q <= '0;
                    iy_q <= '0;
                end else begin
                    if (accept) begin
                        vx_q <= vin_x[gi];
                        vy_q <= vin_y[gi];
                    end
                    // Dropping the fraction bits of a two's-complement value is floor().
                    if (floor_en) begin
                        ix_q <= vx_q[COORD_WIDTH-1:FRAC_BITS];
                        iy_q <= vy_q[COORD_WIDTH-1:FRAC_BITS];
                    end
                end
            end

            assign unused_frac = ^{vx_q[FRAC_BITS-1:0], vy_q[FRAC_BITS-1:0]};
            assign ix[gi] = ix_q;
            assign iy[gi] = iy_q;
        end
    endgenerate

    function automatic logic signed [IW-1:0] min3(input logic signed [IW-1:0] v0,
                                                  input logic signed [IW-1:0] v1,
                                                  input logic signed [IW-1:0] v2);
        logic signed [IW-1:0] m;
        m = (v0 < v1) ? v0 : v1;
        return (m < v2) ? m : v2;
    endfunction

    function automatic logic signed [IW-1:0] max3(input logic signed [IW-1:0] v0,
                                                  input logic signed [IW-1:0] v1,
                                                  input logic signed [IW-1:0] v2);
        logic signed [IW-1:0] m;
        m = (v0 > v1) ? v0 : v1;
        return (m > v2) ? m : v2;
    endfunction

    assign empty = bxmax_q[IW-1] || bymax_q[IW-1] || (bxmin_q > XLIM) || (bymin_q > YLIM);

    // Once the box is known to overlap the screen only one side of each bound can be off-screen.
    assign cx_lo = bxmin_q[IW-1] ? '0 : bxmin_q;
    assign cx_hi = (bxmax_q > XLIM) ? XLIM : bxmax_q;
    assign cy_lo = bymin_q[IW-1] ? '0 : bymin_q;
    assign cy_hi = (bymax_q > YLIM) ? YLIM : bymax_q;

    assign at_last = (px_q == xmax_q) && (py_q == ymax_q);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            bbox_step_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bbox_step_q <= floor_en;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tri_valid) state_d = S_BBOX;
            S_BBOX:   if (bbox_step_q) state_d = S_CLAMP;
            S_CLAMP:  state_d = empty ? S_FINISH : S_SCAN;
            S_SCAN:   if (p_ready && at_last) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bxmin_q <= '0;
            bxmax_q <= '0;
            bymin_q <= '0;
            bymax_q <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            if (minmax_en) begin
                bxmin_q <= min3(ix[0], ix[1], ix[2]);
                bxmax_q <= max3(ix[0], ix[1], ix[2]);
                bymin_q <= min3(iy[0], iy[1], iy[2]);
                bymax_q <= max3(iy[0], iy[1], iy[2]);
            end
            if (state_q == S_CLAMP && !empty) begin
                xmin_q <= cx_lo[PIX_W-1:0];
                xmax_q <= cx_hi[PIX_W-1:0];
                ymax_q <= cy_hi[PIX_W-1:0];
                px_q   <= cx_lo[PIX_W-1:0];
                py_q   <= cy_lo[PIX_W-1:0];
            end
            if (state_q == S_SCAN && p_ready && !at_last) begin
                if (px_q == xmax_q) begin
                    px_q <= xmin_q;
                    py_q <= py_q + 1'b1;
                end else begin
                    px_q <= px_q + 1'b1;
                end
            end
        end
    end

    assign tri_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign p_valid   = (state_q == S_SCAN);
    assign p_last    = (state_q == S_SCAN) && at_last;
    assign done      = (state_q == S_FINISH);
    assign px        = px_q;
    assign py        = py_q;
    assign p[0]      = {{(COORD_WIDTH-PIX_W-FRAC_BITS){1'b0}}, px_q, {FRAC_BITS{1'b0}}};
    assign p[1]      = {{(COORD_WIDTH-PIX_W-FRAC_BITS){1'b0}}, py_q, {FRAC_BITS{1'b0}}};
    assign p[2]      = '0;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Bench for tri_bbox_scanner: table of directed triangles plus random ones, each checked
// pixel-by-pixel against a real-arithmetic reference of the clamped bounding box.
module tb_tri_bbox_scanner;

    localparam int CW = 32;
    localparam int PW = 9;
    localparam int SW = 320;
    localparam int SH = 180;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic signed [2:0][CW-1:0] a, b, c;
    logic                      tri_valid, tri_ready;
    logic signed [2:0][CW-1:0] p;
    logic [PW-1:0]             px, py;
    logic                      p_valid, p_ready, p_last, done, busy;

    tri_bbox_scanner dut (
        .clk_in(clk_in), .rst_in(rst_in), .a(a), .b(b), .c(c),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .p(p), .px(px), .py(py),
        .p_valid(p_valid), .p_ready(p_ready), .p_last(p_last), .done(done), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_x[$];
    int exp_y[$];

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        int mode;
        int n;
        int fx, fy, lx, ly;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int fl(input int v);
        return int'($floor(real'(v) / 65536.0));
    endfunction

    // Reference: every integer pixel of the box spanned by the floored vertices, intersected with the screen.
    function automatic void build_model(input int ax, ay, bx, by, cx, cy);
        int xs[3], ys[3], xlo, xhi, ylo, yhi;
        xs = '{fl(ax), fl(bx), fl(cx)};
        ys = '{fl(ay), fl(by), fl(cy)};
        xlo = xs[0]; xhi = xs[0]; ylo = ys[0]; yhi = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xlo) xlo = xs[i];
            if (xs[i] > xhi) xhi = xs[i];
            if (ys[i] < ylo) ylo = ys[i];
            if (ys[i] > yhi) yhi = ys[i];
        end
        exp_x.delete();
        exp_y.delete();
        if (xlo < 0) xlo = 0;
        if (ylo < 0) ylo = 0;
        if (xhi > SW - 1) xhi = SW - 1;
        if (yhi > SH - 1) yhi = SH - 1;
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endfunction

    // Called on a falling edge with the DUT idle; returns on a falling edge with the DUT idle again.
    task automatic run_tri(input int ax, ay, bx, by, cx, cy, input int mode,
                           output int nhs, output int fx, output int fy, output int lx, output int ly);
        int n, idx, k;
        logic pr;
        logic [95:0] ep;
        build_model(ax, ay, bx, by, cx, cy);
        n = exp_x.size();
        nhs = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        chk("tri_ready_idle", 96'(tri_ready), 96'(1));
        a = {32'($urandom), 32'(ay), 32'(ax)};
        b = {32'($urandom), 32'(by), 32'(bx)};
        c = {32'($urandom), 32'(cy), 32'(cx)};
        tri_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tri_valid = 1'b0;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom};
        for (int cyc = 0; cyc < 3; cyc++) begin
            chk("pre_valid", 96'(p_valid), 96'(0));
            chk("pre_done", 96'(done), 96'(0));
            chk("pre_busy", 96'(busy), 96'(1));
            @(posedge clk_in);
            @(negedge clk_in);
        end
        idx = 0;
        k = 0;
        while (idx < n && k < 4 * n + 20) begin
            ep = {32'd0, 32'(exp_y[idx]) << 16, 32'(exp_x[idx]) << 16};
            chk("p_valid", 96'(p_valid), 96'(1));
            chk("px", 96'(px), 96'(exp_x[idx]));
            chk("py", 96'(py), 96'(exp_y[idx]));
            chk("p_vec", p, ep);
            chk("p_last", 96'(p_last), 96'(idx == n - 1));
            chk("scan_done", 96'(done), 96'(0));
            pr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            p_ready = pr;
            if (pr && p_valid) begin
                if (nhs == 0) begin fx = int'(px); fy = int'(py); end
                lx = int'(px); ly = int'(py);
                nhs++;
                idx++;
            end
            @(posedge clk_in);
            @(negedge clk_in);
            k++;
        end
        chk("scan_count", 96'(idx), 96'(n));
        p_ready = 1'($urandom_range(0, 1));
        chk("done_pulse", 96'(done), 96'(1));
        chk("fin_valid", 96'(p_valid), 96'(0));
        chk("fin_ready", 96'(tri_ready), 96'(0));
        @(posedge clk_in);
        @(negedge clk_in);
        chk("done_clear", 96'(done), 96'(0));
        chk("ready_back", 96'(tri_ready), 96'(1));
        chk("busy_clear", 96'(busy), 96'(0));
    endtask

    initial begin
        int nhs, fx, fy, lx, ly;
        tbl[0] = '{98304, 147456, 196608, 131072, 131072, 311296, 0, 9, 1, 2, 3, 4};
        tbl[1] = '{98304, 147456, 196608, 131072, 131072, 311296, 1, 9, 1, 2, 3, 4};
        tbl[2] = '{-327680, 655360, 26214400, 688128, 6553600, 786432, 0, 960, 0, 10, 319, 12};
        tbl[3] = '{-524288, 327680, -229376, 393216, -81920, 458752, 0, 0, -1, -1, -1, -1};
        tbl[4] = '{517734, 465306, 517734, 465306, 517734, 465306, 0, 1, 7, 7, 7, 7};
        tbl[5] = '{20853964, 11698176, 21626880, 12451840, 21000000, 12000000, 2, 4, 318, 178, 319, 179};
        tbl[6] = '{655360, 11796480, 983040, 12000000, 700000, 13000000, 0, 0, -1, -1, -1, -1};
        tbl[7] = '{-32768, 32768, 65536, 0, 16384, 124518, 1, 4, 0, 0, 1, 1};

        rst_in = 1'b0;
        tri_valid = 1'b0;
        p_ready = 1'b0;
        a = '0; b = '0; c = '0;
        @(negedge clk_in);
        chk("rst_tri_ready", 96'(tri_ready), 96'(1));
        chk("rst_p_valid", 96'(p_valid), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_pxy", 96'({px, py}), 96'(0));
        rst_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 8; i++) begin
            run_tri(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].cx, tbl[i].cy, tbl[i].mode,
                    nhs, fx, fy, lx, ly);
            chk($sformatf("tbl%0d_count", i), 96'(nhs), 96'(tbl[i].n));
            if (tbl[i].n > 0) begin
                chk($sformatf("tbl%0d_first", i), 96'({fx, fy}), 96'({tbl[i].fx, tbl[i].fy}));
                chk($sformatf("tbl%0d_last", i), 96'({lx, ly}), 96'({tbl[i].lx, tbl[i].ly}));
            end
            $display("vec %0d: %0d points, first (%0d,%0d) last (%0d,%0d)", i, nhs, fx, fy, lx, ly);
        end

        // Reset in the middle of a scan: outputs must drop before the next clock edge.
        a = {32'd0, 32'd147456, 32'd98304};
        b = {32'd0, 32'd131072, 32'd196608};
        c = {32'd0, 32'd311296, 32'd131072};
        tri_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tri_valid = 1'b0;
        p_ready = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("pre_abort_valid", 96'(p_valid), 96'(1));
        #2 rst_in = 1'b0;
        #1;
        chk("abort_valid", 96'(p_valid), 96'(0));
        chk("abort_done", 96'(done), 96'(0));
        chk("abort_busy", 96'(busy), 96'(0));
        chk("abort_ready", 96'(tri_ready), 96'(1));
        @(negedge clk_in);
        chk("abort_hold_done", 96'(done), 96'(0));
        rst_in = 1'b1;
        @(negedge clk_in);
        run_tri(517734, 465306, 517734, 465306, 517734, 465306, 0, nhs, fx, fy, lx, ly);
        chk("post_rst_first", 96'({fx, fy}), 96'({32'd7, 32'd7}));
        $display("post-reset: %0d points at (%0d,%0d)", nhs, fx, fy);

        for (int r = 0; r < 20; r++) begin
            int bxp, byp;
            int vx[3], vy[3];
            bxp = int'($urandom_range(0, 370)) - 30;
            byp = int'($urandom_range(0, 220)) - 25;
            for (int v = 0; v < 3; v++) begin
                vx[v] = (bxp + int'($urandom_range(0, 10))) * 65536 + int'($urandom_range(0, 65535));
                vy[v] = (byp + int'($urandom_range(0, 8))) * 65536 + int'($urandom_range(0, 65535));
            end
            run_tri(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2], 2, nhs, fx, fy, lx, ly);
            chk("rand_count", 96'(nhs), 96'(exp_x.size()));
            $display("rand %0d: %0d points, first (%0d,%0d) last (%0d,%0d)", r, nhs, fx, fy, lx, ly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tri_bbox_scanner.md
Name: tri_bbox_scanner

Overview:
- Upstream feeder for the barycentric stage.
- Accepts one triangle's three vertices in signed 16.16 fixed point and computes the integer pixel bounding box, clamped to the screen.
- Emits each pixel centre-less sample point p in raster order (x fastest) over a valid/ready stream, with a last flag and a per-triangle done pulse.

Parameters:
COORD_WIDTH, 32, width of each fixed-point coordinate component
FRAC_BITS, 16, fractional bits of coordinates (COORD_WIDTH/2 convention)
SCREEN_W, 320, screen width in pixels
SCREEN_H, 180, screen height in pixels
PIX_W, $clog2(max(SCREEN_W,SCREEN_H)), width of integer pixel indices

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
a, b, c  input  [2:0][COORD_WIDTH-1:0] signed  triangle vertices; [0]=x, [1]=y, [2]=z (z ignored)
tri_valid  input  1  vertices valid
tri_ready  output  1  block can accept a triangle (high only in IDLE)
p  output  [2:0][COORD_WIDTH-1:0] signed  sample point: x=px<<FRAC_BITS, y=py<<FRAC_BITS, z=0
px, py  output  PIX_W each  integer pixel indices of p
p_valid  output  1  p/px/py valid
p_ready  input  1  downstream accepts p
p_last  output  1  current p is final pixel of triangle
done  output  1  one-cycle pulse when triangle fully emitted (or empty)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset is asynchronous, active-low (rst_in=0), one clock, clk_in. All outputs reset to 0 except tri_ready=1; state=IDLE; internal bounds/counters=0. Reset asserted mid-scan aborts immediately; no done pulse.
- States: IDLE, BBOX, CLAMP, SCAN, FINISH.
- IDLE: tri_ready=1. On tri_valid&&tri_ready, register a,b,c, go to BBOX.
- BBOX: integer part of each x,y = arithmetic shift right by FRAC_BITS (floor, correct for negatives). Register xmin/xmax/ymin/ymax as signed min/max over three vertices. Go to CLAMP.
- CLAMP: empty if xmax<0 or ymax<0 or xmin>SCREEN_W-1 or ymin>SCREEN_H-1 -> go to FINISH without emitting. Otherwise clamp each bound to [0,SCREEN_W-1] / [0,SCREEN_H-1], load px=xmin, py=ymin, go to SCAN.
- Latency: acceptance at edge T; p_valid first high after edge T+3 (empty: done high after edge T+3).
- SCAN: p_valid=1; p_last=(px==xmax && py==ymax). Outputs held stable while p_valid && !p_ready. On handshake: if p_last, go to FINISH; else if px==xmax then px<=xmin, py<=py+1; else px<=px+1. One pixel per cycle at full throughput.
- FINISH: p_valid=0, done=1 for exactly one cycle, return to IDLE. tri_valid during FINISH is not accepted (tri_ready=0); it is accepted on the following IDLE cycle, so minimum triangle-to-triangle gap is 1 idle cycle.
- Degenerate (all vertices in one pixel) emits exactly one point with p_last=1.
- Pixel count = (xmax-xmin+1)*(ymax-ymin+1) after clamp; no overflow since bounds lie within screen.
- Vertex inputs are sampled only at acceptance; changes afterward have no effect.

Test Plan:
- a=(1.5,2.25), b=(3.0,2.0), c=(2.0,4.75) with p_ready=1 -> first p_valid 3 cycles after accept at px,py=(1,2), p.x=0x00010000, p.y=0x00020000; 9 consecutive points (1,2),(2,2),(3,2),(1,3)...(3,4); p_last only on (3,4); done pulses the cycle after.
- Same triangle, p_ready toggled 1,0,0,1,... -> no point skipped or duplicated, p/px/py stable while stalled, exactly 9 handshakes.
- a=(-5.0,10.0), b=(400.0,10.5), c=(100.0,12.0) -> xmin=0, xmax=319, y 10..12; 960 points; last=(319,12).
- All vertices x<0 (e.g. -8.0,-3.5,-1.25) -> p_valid never asserts; done pulses after edge T+3; tri_ready returns high next cycle.
- a=b=c=(7.9,7.1) -> single point (7,7), p_last=1, then done.
- rst_in driven low mid-scan of first test -> p_valid, done, busy drop to 0 immediately (asynchronously); tri_ready=1; a new triangle after release scans from its own bbox start.
